// File: rtl/bus_copy_engine.sv
// Memory-bus copy engine: moves a block of 32-bit words from a source to a destination range.
// Optional pattern fill (no source reads) is compiled in with `define BUS_COPY_FILL_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for cfg_go; zero-length go only pulses done
// RD_REQ   | read start pulse at the current source address
// RD_ACK   | waiting for the responder to raise busy
// RD_WAIT  | waiting for busy to fall, then capture q into the buffer
// WR_REQ   | write start pulse of the buffer to the current destination
// WR_ACK   | waiting for the responder to raise busy
// WR_WAIT  | waiting for busy to fall, then step counters
// DONE     | one-cycle completion pulse
module bus_copy_engine #(
   parameter int ADDR_W = 27,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic [ADDR_W-1:0] cfg_src,
   input  logic [ADDR_W-1:0] cfg_dst,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              cfg_go,
   input  logic              cfg_abort,
`ifdef BUS_COPY_FILL_EN
   input  logic              cfg_fill,
   input  logic [31:0]       cfg_pattern,
`endif
   output logic              active,
   output logic              done,
   output logic [LEN_W-1:0]  remaining,
   output logic [ADDR_W-1:0] address,
   output logic [31:0]       data,
   output logic              we,
   output logic              start,
   input  logic              busy,
   input  logic [31:0]       q
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_ACK, S_RD_WAIT, S_WR_REQ, S_WR_ACK, S_WR_WAIT, S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

   state_t            state, state_next;
   logic [ADDR_W-1:0] src_q, dst_q, address_q;
   logic [LEN_W-1:0]  remaining_q;
   logic [31:0]       buf_q;
   logic              we_q, abort_q, zero_done_q;
   logic              go_ok, wr_last, fill_mode, fill_start;

`ifdef BUS_COPY_FILL_EN
   logic fill_q;
   assign fill_mode  = fill_q;
   assign fill_start = cfg_fill;
`else
   assign fill_mode  = 1'b0;
   assign fill_start = 1'b0;
`endif

   assign go_ok   = cfg_go && (cfg_len != '0);
   // A pending abort finishes the current word, never splits a read from its write.
   assign wr_last = (remaining_q == LEN_ONE) || abort_q || cfg_abort;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= S_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:    if (go_ok) state_next = fill_start ? S_WR_REQ : S_RD_REQ;
         S_RD_REQ:  state_next = S_RD_ACK;
         S_RD_ACK:  if (busy) state_next = S_RD_WAIT;
         S_RD_WAIT: if (!busy) state_next = S_WR_REQ;
         S_WR_REQ:  state_next = S_WR_ACK;
         S_WR_ACK:  if (busy) state_next = S_WR_WAIT;
         S_WR_WAIT: if (!busy) begin
            if (wr_last)        state_next = S_DONE;
            else if (fill_mode) state_next = S_WR_REQ;
            else                state_next = S_RD_REQ;
         end
         S_DONE:    state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   always_comb begin
      active = (state != S_IDLE);
      start  = (state == S_RD_REQ) || (state == S_WR_REQ);
      done   = (state == S_DONE) || zero_done_q;
   end

   assign address   = address_q;
   assign data      = buf_q;
   assign we        = we_q;
   assign remaining = remaining_q;

   // Bus address and we are loaded one edge ahead of the request state so they are
   // stable from the start pulse until the transaction ends.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         src_q       <= '0;
         dst_q       <= '0;
         address_q   <= '0;
         remaining_q <= '0;
         buf_q       <= '0;
         we_q        <= 1'b0;
         abort_q     <= 1'b0;
         zero_done_q <= 1'b0;
`ifdef BUS_COPY_FILL_EN
         fill_q      <= 1'b0;
`endif
      end else begin
         zero_done_q <= (state == S_IDLE) && cfg_go && (cfg_len == '0);

         if (state_next == S_IDLE)                  abort_q <= 1'b0;
         else if ((state != S_IDLE) && cfg_abort)   abort_q <= 1'b1;

         unique case (state)
            S_IDLE: if (go_ok) begin
               src_q       <= cfg_src;
               dst_q       <= cfg_dst;
               remaining_q <= cfg_len;
`ifdef BUS_COPY_FILL_EN
               fill_q      <= cfg_fill;
               if (cfg_fill) begin
                  buf_q     <= cfg_pattern;
                  address_q <= cfg_dst;
                  we_q      <= 1'b1;
               end else begin
                  address_q <= cfg_src;
                  we_q      <= 1'b0;
               end
`else
               address_q   <= cfg_src;
               we_q        <= 1'b0;
`endif
            end
            S_RD_WAIT: if (!busy) begin
               buf_q     <= q;
               address_q <= dst_q;
               we_q      <= 1'b1;
            end
            S_WR_WAIT: if (!busy) begin
               remaining_q <= remaining_q - LEN_ONE;
               dst_q       <= dst_q + ADDR_ONE;
               if (!fill_mode) src_q <= src_q + ADDR_ONE;
               if (wr_last) begin
                  we_q <= 1'b0;
               end else if (fill_mode) begin
                  address_q <= dst_q + ADDR_ONE;
               end else begin
                  address_q <= src_q + ADDR_ONE;
                  we_q      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_copy_engine.sv
// Self-checking bench for bus_copy_engine: table vectors, random copies and multi-cycle corner cases
// against a word-level copy model and a behavioural bus responder.
module tb_bus_copy_engine;
   localparam int ADDR_W = 27;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              nreset = 1'b0;
   logic [ADDR_W-1:0] cfg_src = '0, cfg_dst = '0;
   logic [LEN_W-1:0]  cfg_len = '0;
   logic              cfg_go = 1'b0, cfg_abort = 1'b0;
`ifdef BUS_COPY_FILL_EN
   logic              cfg_fill = 1'b0;
   logic [31:0]       cfg_pattern = '0;
`endif
   logic              active, done, we, start;
   logic [LEN_W-1:0]  remaining;
   logic [ADDR_W-1:0] address;
   logic [31:0]       data;
   logic              busy = 1'b0;
   logic [31:0]       q = '0;

   always #5 clk = ~clk;

   bus_copy_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .nreset(nreset),
      .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
      .cfg_go(cfg_go), .cfg_abort(cfg_abort),
`ifdef BUS_COPY_FILL_EN
      .cfg_fill(cfg_fill), .cfg_pattern(cfg_pattern),
`endif
      .active(active), .done(done), .remaining(remaining),
      .address(address), .data(data), .we(we), .start(start),
      .busy(busy), .q(q)
   );

   typedef struct { logic we; logic [26:0] addr; logic [31:0] data; } txn_t;
   typedef struct { logic [26:0] src; logic [26:0] dst; logic [15:0] len;
                    int dly; int blen; logic [15:0] exp_rem; int exp_txn; } vec_t;

   txn_t log_q[$];
   txn_t exp_q[$];
   bit [31:0] rmem   [bit [26:0]];
   bit [31:0] refmem [bit [26:0]];

   int passed = 0, total = 0;
   int done_cnt = 0, stab_err = 0;
   bit active_seen = 0;
   int dly_cfg = 1, blen_cfg = 1;

   function automatic logic [31:0] init_val(logic [26:0] a);
      return {5'h15, a} ^ 32'h3C96_1E2D;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Responder and monitor: logs every transaction, answers after dly cycles, holds busy for blen.
   initial begin : responder
      int   r_state, r_cnt;
      txn_t cur;
      r_state = 0; r_cnt = 0;
      forever begin
         @(posedge clk); #1;
         if (!nreset) begin
            r_state = 0; busy = 1'b0;
            continue;
         end
         if (done)   done_cnt++;
         if (active) active_seen = 1;
         if (start && r_state != 0) stab_err++;
         case (r_state)
            0: if (start) begin
               cur.we = we; cur.addr = address; cur.data = data;
               log_q.push_back(cur);
               r_cnt = (dly_cfg > 0) ? dly_cfg : int'($urandom_range(1, 3));
               r_state = 1;
            end
            1: begin
               r_cnt--;
               if (r_cnt <= 0) begin
                  busy = 1'b1;
                  r_cnt = (blen_cfg > 0) ? blen_cfg : int'($urandom_range(1, 3));
                  r_state = 2;
               end
            end
            default: begin
               r_cnt--;
               if (r_cnt <= 0) begin
                  if (we !== cur.we || address !== cur.addr || data !== cur.data) stab_err++;
                  if (cur.we) rmem[cur.addr] = cur.data;
                  else q = rmem.exists(cur.addr) ? rmem[cur.addr] : init_val(cur.addr);
                  busy = 1'b0;
                  r_state = 0;
               end
            end
         endcase
      end
   end

   task automatic clear_mem();
      rmem.delete();
      refmem.delete();
   endtask

   // Word-level reference: ascending copy, 27-bit address wrap, fill skips the reads.
   task automatic build_expected(logic [26:0] s, logic [26:0] d, int n, bit fill, logic [31:0] pat);
      txn_t t;
      logic [26:0] a, b;
      logic [31:0] v;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         a = s + 27'(i);
         b = d + 27'(i);
         if (fill) v = pat;
         else begin
            v = refmem.exists(a) ? refmem[a] : init_val(a);
            t.we = 1'b0; t.addr = a; t.data = '0;
            exp_q.push_back(t);
         end
         t.we = 1'b1; t.addr = b; t.data = v;
         exp_q.push_back(t);
         refmem[b] = v;
      end
   endtask

   task automatic compare_log(string nm);
      logic [63:0] act, exp;
      int n;
      check({nm, " txn_count"}, 64'(log_q.size()), 64'(exp_q.size()));
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         act = {3'b0, log_q[i].we, log_q[i].addr, (log_q[i].we ? log_q[i].data : 32'h0)};
         exp = {3'b0, exp_q[i].we, exp_q[i].addr, (exp_q[i].we ? exp_q[i].data : 32'h0)};
         check($sformatf("%s txn%0d", nm, i), act, exp);
      end
   endtask

   task automatic wait_done(string nm, int bound);
      bit ok;
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done_cnt > 0) begin ok = 1; break; end
      end
      if (!ok) begin
         total++;
         $display("FAIL %s: done timeout after %0d cycles, expected a done pulse", nm, bound);
      end
   endtask

   task automatic launch(logic [26:0] s, logic [26:0] d, logic [15:0] n, int dl, int bl,
                         bit abort_go, bit fill, logic [31:0] pat);
      log_q.delete();
      done_cnt = 0; active_seen = 0; stab_err = 0;
      dly_cfg = dl; blen_cfg = bl;
      @(negedge clk);
      cfg_src = s; cfg_dst = d; cfg_len = n; cfg_go = 1'b1; cfg_abort = abort_go;
`ifdef BUS_COPY_FILL_EN
      cfg_fill = fill; cfg_pattern = pat;
`else
      if (fill || pat != '0) $display("note: fill requested in a build without fill support");
`endif
      @(negedge clk);
      cfg_go = 1'b0; cfg_abort = 1'b0;
   endtask

   task automatic do_run(string nm, logic [26:0] s, logic [26:0] d, logic [15:0] n, int dl, int bl,
                         bit abort_go, bit fill, logic [31:0] pat, logic [15:0] exp_rem);
      clear_mem();
      build_expected(s, d, int'(n), fill, pat);
      launch(s, d, n, dl, bl, abort_go, fill, pat);
      wait_done(nm, int'(n) * 30 + 50);
      repeat (3) @(negedge clk);
      compare_log(nm);
      check({nm, " remaining"}, 64'(remaining), 64'(exp_rem));
      check({nm, " done_pulses"}, 64'(done_cnt), 64'd1);
      check({nm, " active_idle"}, 64'(active), 64'd0);
      check({nm, " bus_stable"}, 64'(stab_err), 64'd0);
   endtask

   vec_t vecs[5];

   initial begin : main
      bit ok;
      int cnt;
      vecs[0] = '{src: 27'h100,     dst: 27'h200,     len: 16'd4, dly: 1, blen: 2, exp_rem: 16'd0, exp_txn: 8};
      vecs[1] = '{src: 27'h7FFFFFE, dst: 27'h10,      len: 16'd3, dly: 1, blen: 1, exp_rem: 16'd0, exp_txn: 6};
      vecs[2] = '{src: 27'h20,      dst: 27'h7FFFFFF, len: 16'd2, dly: 2, blen: 1, exp_rem: 16'd0, exp_txn: 4};
      vecs[3] = '{src: 27'h10,      dst: 27'h12,      len: 16'd5, dly: 1, blen: 1, exp_rem: 16'd0, exp_txn: 10};
      vecs[4] = '{src: 27'h3ABCDEF, dst: 27'h1234567, len: 16'd1, dly: 3, blen: 3, exp_rem: 16'd0, exp_txn: 2};

      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({active, done, start, we, remaining, address, data}), 64'd0);
      nreset = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) begin
         do_run($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].len,
                vecs[i].dly, vecs[i].blen, 1'b0, 1'b0, 32'h0, vecs[i].exp_rem);
         check($sformatf("vec%0d txn_total", i), 64'(log_q.size()), 64'(vecs[i].exp_txn));
      end

      for (int i = 0; i < 6; i++) begin
         do_run($sformatf("rand%0d", i), 27'($urandom()), 27'($urandom()),
                16'($urandom_range(1, 5)), 0, 0, 1'b0, 1'b0, 32'h0, 16'd0);
      end

      // go and abort together in IDLE: the copy runs to completion
      do_run("go_with_abort", 27'h40, 27'h80, 16'd2, 1, 1, 1'b1, 1'b0, 32'h0, 16'd0);

      // Zero length: done the cycle after go, no bus activity
      log_q.delete(); done_cnt = 0; active_seen = 0;
      @(negedge clk);
      cfg_len = '0; cfg_go = 1'b1;
      @(negedge clk);
      cfg_go = 1'b0;
      check("zero_len done", 64'(done), 64'd1);
      @(negedge clk);
      check("zero_len done_single", 64'(done), 64'd0);
      repeat (2) @(negedge clk);
      check("zero_len no_start", 64'(log_q.size()), 64'd0);
      check("zero_len active", 64'(active_seen), 64'd0);

      // Minimum latency: 6 cycles per word with a one-cycle busy
      clear_mem();
      log_q.delete(); done_cnt = 0; dly_cfg = 1; blen_cfg = 1;
      @(negedge clk);
      cfg_src = 27'h900; cfg_dst = 27'hA00; cfg_len = 16'd2; cfg_go = 1'b1;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) cfg_go = 1'b0;
         if (done_cnt > 0) break;
      end
      check("latency_2words", 64'(cnt), 64'd13);

      // Abort during the third read's busy: the third write still lands
      clear_mem();
      build_expected(27'h300, 27'h400, 3, 1'b0, 32'h0);
      launch(27'h300, 27'h400, 16'd10, 1, 3, 1'b0, 1'b0, 32'h0);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (log_q.size() == 5 && busy) begin ok = 1; break; end
         @(negedge clk);
      end
      check("abort reached_read3", 64'(ok), 64'd1);
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_abort = 1'b0;
      wait_done("abort", 200);
      repeat (10) @(negedge clk);
      compare_log("abort");
      check("abort remaining", 64'(remaining), 64'd7);
      check("abort done_pulses", 64'(done_cnt), 64'd1);

      // Async reset while the first write is in WR_WAIT
      clear_mem();
      launch(27'h500, 27'h600, 16'd4, 1, 3, 1'b0, 1'b0, 32'h0);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (log_q.size() == 2 && busy) begin ok = 1; break; end
         @(negedge clk);
      end
      check("reset reached_wr_busy", 64'(ok), 64'd1);
      @(negedge clk);
      nreset = 1'b0;
      #1;
      check("reset mid_write", 64'({active, done, start, we, remaining, address, data}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      nreset = 1'b1;
      do_run("post_reset", 27'h700, 27'h710, 16'd1, 1, 2, 1'b0, 1'b0, 32'h0, 16'd0);

`ifdef BUS_COPY_FILL_EN
      do_run("fill", 27'h0, 27'h40, 16'd3, 1, 1, 1'b0, 1'b1, 32'hDEADBEEF, 16'd0);
      cfg_fill = 1'b0;
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/bus_copy_engine.md
Name: bus_copy_engine

Overview:
- Memory-bus initiator (DMA engine) that copies a block of 32-bit words from a source to a destination address range.
- Drives the same address/data/we/start/busy/q bus that the CPU uses toward the memory unit, as an alternate bus master; top-level arbitration is outside this block.
- Configured through a flat register-style port. Raises a one-cycle done pulse suitable for an interrupt input.

Parameters:
- ADDR_W, 27, bus word-address width.
- LEN_W, 16, width of transfer length counter (max words = 2^LEN_W-1).

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- cfg_src  in  ADDR_W  source start word address, sampled on go
- cfg_dst  in  ADDR_W  destination start word address, sampled on go
- cfg_len  in  LEN_W  number of words to copy, sampled on go
- cfg_go  in  1  start request, level-sampled only in IDLE
- cfg_abort  in  1  stop after current bus transaction
- active  out  1  high while not IDLE
- done  out  1  one-cycle pulse on completion or abort
- remaining  out  LEN_W  words not yet written
- address  out  ADDR_W  bus address
- data  out  32  bus write data
- we  out  1  bus write enable
- start  out  1  bus transaction start, one-cycle pulse
- busy  in  1  responder busy
- q  in  32  responder read data

Behaviour:
- Reset (async, nreset=0):
  - state=IDLE; active, done, start, we = 0; address, data, remaining = 0; internal src, dst and buffer registers = 0.
- Bus contract:
  - start is pulsed for exactly 1 cycle, with address, data and we stable from that cycle until the transaction ends.
  - Responder raises busy at some cycle ≥1 after start.
  - Transaction ends on the first cycle busy=0 after having been 1; q is captured on that cycle.
  - address, data and we hold their values while waiting.
- States:
  - IDLE:
    - cfg_go=1 and cfg_len≠0: latch src, dst, len; remaining=len; go to RD_REQ.
    - cfg_go=1 and cfg_len=0: pulse done next cycle, stay IDLE, no bus activity.
  - RD_REQ: address=src, we=0, start=1 → RD_ACK.
  - RD_ACK: wait busy=1 → RD_WAIT.
  - RD_WAIT: on busy=0, buf=q → WR_REQ.
  - WR_REQ: address=dst, data=buf, we=1, start=1 → WR_ACK.
  - WR_ACK: wait busy=1 → WR_WAIT.
  - WR_WAIT: on busy=0:
    - remaining−=1, src+=1, dst+=1.
    - If remaining becomes 0 or abort is latched → DONE; else → RD_REQ.
  - DONE: done=1 for one cycle, we=0 → IDLE.
- Latency: 2 bus transactions per word plus 2 cycles of request/ack overhead each; minimum 6 cycles per word when busy is high for one cycle.
- Address arithmetic: modulo 2^ADDR_W; wraps from all-ones to 0 silently.
- cfg_abort:
  - Sticky latch, set when cfg_abort=1 in any non-IDLE state; cleared on entering IDLE.
  - If set during a read, the read finishes and the pending write is still performed, so no word is left half-copied; then → DONE.
  - remaining reports the uncopied count.
- cfg_go outside IDLE is ignored. cfg_go and cfg_abort together in IDLE: go is honoured, abort is ignored.
- Overlapping ranges: strictly ascending copy, no overlap handling.
- nreset asserted mid-transaction: immediate return to reset values. The responder is expected to be reset by the same signal.

Optional Feature:
- Macro BUS_COPY_FILL_EN.
- Defined:
  - Adds input cfg_fill (1 bit) and input cfg_pattern (32 bits), both sampled on go.
  - When cfg_fill=1: RD_REQ/RD_ACK/RD_WAIT are skipped, buf=cfg_pattern, src is not incremented, and each word costs one bus transaction.
- Undefined: ports absent; the engine always copies.

Test Plan:
- Basic copy: src=0x100, dst=0x200, len=4, responder busy for 2 cycles.
  - Bus shows exactly 4 reads (0x100–0x103) and 4 writes (0x200–0x203).
  - Written data equals the read q values; one done pulse; remaining=0; active falls.
- Zero length: len=0, go=1.
  - No start pulse; done pulses the cycle after go; active stays 0.
- Address wrap: src=0x7FFFFFE, dst=0x0000010, len=3.
  - Reads at 0x7FFFFFE, 0x7FFFFFF, 0x0000000.
- Abort mid-read: len=10, abort asserted during the 3rd read's busy.
  - 3rd write still occurs at dst+2; then done; remaining=7; no 4th read.
- Async reset mid-write: nreset=0 during WR_WAIT.
  - All outputs 0 within the same cycle; after release, a new go with len=1 completes normally.
- BUS_COPY_FILL_EN: fill=1, pattern=0xDEADBEEF, dst=0x40, len=3.
  - 3 writes of 0xDEADBEEF to 0x40–0x42; zero read transactions.
